sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
Round-robin arbiter and burst sequencer that shares the single sprite/glyph ROM read port among NUM_REQ sprite engines (player ship, enemies, bullets, score). Sits in the pixel_clk domain beside video_gen. Fetches are allowed only while fetch_en is high, typically driven from hblank. Each grant issues one address-incrementing burst and returns tagged ROM data after the fixed ROM latency.

Parameters:
NUM_REQ, 4, number of requesters
ADDR_W, 12, ROM address width
DATA_W, 12, ROM word width (RGB444)
ROM_LAT, 2, ROM read latency in cycles, from rom_en/rom_addr to rom_data valid (≥1)
BURST_MAX, 16, maximum words per burst; LEN_W = $clog2(BURST_MAX+1)

Ports:
pixel_clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_en  in  1  grants may be issued only while high
req  in  NUM_REQ  per-requester request, held until granted
req_addr  in  NUM_REQ*ADDR_W  per-requester base address; requester i uses slice i
req_len  in  NUM_REQ*LEN_W  per-requester burst length in words
grant  out  NUM_REQ  one-hot, pulses 1 cycle
busy  out  1  high in ISSUE or DRAIN
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_data  in  DATA_W  ROM read data, ROM_LAT cycles after rom_en
rsp_valid  out  1  response word valid
rsp_id  out  $clog2(NUM_REQ)  requester index of the response
rsp_data  out  DATA_W  equals rom_data while rsp_valid is high
rsp_last  out  1  final word of the burst

Behaviour:
- Reset: state=IDLE; grant=0, busy=0, rom_en=0, rom_addr=0; rsp_valid=0, rsp_id=0, rsp_last=0. RR pointer=0. Response pipeline cleared, so in-flight words are dropped and no rsp_valid follows. Reset has priority over all other events.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - When fetch_en=1 and req≠0, select the first asserted req scanning from ptr upward, modulo NUM_REQ.
  - In that cycle T: grant[i]=1; latch base=req_addr[i], id=i, len=req_len[i].
  - Length rules: len=0 is treated as 1; len>BURST_MAX is clamped to BURST_MAX.
  - Set ptr=(i+1) mod NUM_REQ. Go to ISSUE.
  - When fetch_en=0 or req=0: no grant, stay in IDLE.
- ISSUE, cycles T+1..T+len:
  - rom_en=1, rom_addr=(base+cnt) mod 2^ADDR_W, with cnt running 0..len-1.
  - Address wraps silently at 2^ADDR_W.
  - After cnt=len-1, go to DRAIN.
  - fetch_en falling mid-burst does not abort; the burst completes.
- DRAIN, cycles T+len+1..T+len+ROM_LAT: rom_en=0. Then go to IDLE, so IDLE is reached at T+len+ROM_LAT+1. The earliest next grant is in that cycle.
- Response pipeline: shift register of {valid, last, id}, depth ROM_LAT, fed by {rom_en, cnt==len-1, id}.
  - rsp_valid is high on cycles T+1+ROM_LAT .. T+len+ROM_LAT.
  - rsp_last is high only on the final valid cycle.
  - rsp_id is constant for the whole burst.
  - rsp_data = rom_data, combinational pass-through.
  - When rsp_valid=0, rsp_id and rsp_last are 0.
- The response side has no backpressure; requesters must accept every word.
- A requester dropping req before grant: no grant. A req still held after grant is treated as a new request and competes again under round-robin.
- Simultaneous requests: a strict round-robin rotation, so with NUM_REQ saturating requesters each is granted exactly once per NUM_REQ grants.
- rom_en is never high outside ISSUE. grant is never high outside IDLE.

Test Plan:
- Single request: req=0001, req_addr0=0x100, len=3, fetch_en=1. grant=0001 at T. rom_addr 0x100, 0x101, 0x102 at T+1..T+3. rsp_valid at T+3..T+5 (ROM_LAT=2), rsp_id=0, rsp_last at T+5. busy falls and IDLE is reached at T+6.
- Round robin: req=1111 held, all len=1. Grant order is 0,1,2,3,0 with a 4-cycle spacing (1+1+2). A request reasserted right after grant waits its turn.
- Gating: fetch_en=0 with req=0010 gives no grant. Raising fetch_en grants the next cycle. Dropping fetch_en mid-burst still yields all len responses.
- Wrap and length edge cases:
  - base=0xFFE, len=4 gives addresses 0xFFE, 0xFFF, 0x000, 0x001.
  - len=0 gives exactly 1 word with rsp_last=1.
  - len=31 is clamped to 16 words.
- Reset mid-burst: assert reset at the 2nd ISSUE cycle. The next cycle has all outputs 0 and no further rsp_valid. After release, req=1000 and req=0001 together yield grant=0001 first (ptr reset to 0).
- Data integrity: a ROM model with data=addr^0xABC and random reqs/lengths over 1000 bursts. A scoreboard checks each rsp_data, rsp_id, word count and rsp_last against the expected bursts.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one sprite/glyph ROM read port
// among NUM_REQ sprite engines, returning tagged ROM words after the fixed latency.
module sprite_rom_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 12,
   parameter int ROM_LAT   = 2,
   parameter int BURST_MAX = 16,
   parameter int LEN_W     = $clog2(BURST_MAX + 1),
   parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       pixel_clk,
   input  logic                       reset,
   input  logic                       fetch_en,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*LEN_W-1:0]   req_len,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       busy,
   output logic                       rom_en,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [DATA_W-1:0]          rom_data,
   output logic                       rsp_valid,
   output logic [ID_W-1:0]            rsp_id,
   output logic [DATA_W-1:0]          rsp_data,
   output logic                       rsp_last
);

   localparam int CNT_MAX = (BURST_MAX > ROM_LAT) ? BURST_MAX : ROM_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t              state_r, state_nx;
   logic [ID_W-1:0]     ptr_r, id_r, sel_id;
   logic [ADDR_W-1:0]   base_r;
   logic [CNT_W-1:0]    cnt_r, last_idx_r;
   logic [LEN_W-1:0]    raw_len, sel_len;
   logic                found, take, issue_last;
   int                  idx;

   logic                valid_p [ROM_LAT];
   logic                last_p  [ROM_LAT];
   logic [ID_W-1:0]     id_p    [ROM_LAT];

   // Round-robin scan from ptr, length clamp, and next-state decode.
   always_comb begin
      state_nx = state_r;
      found    = 1'b0;
      sel_id   = '0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_r) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            sel_id = ID_W'(idx);
         end
      end
      raw_len = req_len[sel_id*LEN_W +: LEN_W];
      if (raw_len == '0) begin
         sel_len = LEN_W'(1);
      end else if (raw_len > LEN_W'(BURST_MAX)) begin
         sel_len = LEN_W'(BURST_MAX);
      end else begin
         sel_len = raw_len;
      end
      take       = (state_r == IDLE) && fetch_en && found;
      issue_last = (cnt_r == last_idx_r);
      case (state_r)
         IDLE:    state_nx = take ? ISSUE : IDLE;
         ISSUE:   state_nx = issue_last ? DRAIN : ISSUE;
         DRAIN:   state_nx = (cnt_r == CNT_W'(ROM_LAT - 1)) ? IDLE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end

   // Grant is combinational in the IDLE cycle; reset suppresses it.
   always_comb begin
      grant = '0;
      if (take && !reset) begin
         grant[sel_id] = 1'b1;
      end else begin
         grant = '0;
      end
   end

   assign busy     = (state_r != IDLE);
   assign rom_en   = (state_r == ISSUE);
   assign rom_addr = rom_en ? (base_r + ADDR_W'(cnt_r)) : '0;

   // State register.
   always_ff @(posedge pixel_clk) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_nx;
   end

   // Burst context, round-robin pointer and shared issue/drain counter.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         ptr_r      <= '0;
         id_r       <= '0;
         base_r     <= '0;
         cnt_r      <= '0;
         last_idx_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               cnt_r <= '0;
               if (take) begin
                  id_r       <= sel_id;
                  base_r     <= req_addr[sel_id*ADDR_W +: ADDR_W];
                  last_idx_r <= CNT_W'(sel_len) - CNT_W'(1);
                  ptr_r      <= (int'(sel_id) == NUM_REQ - 1) ? '0 : sel_id + ID_W'(1);
               end
            end
            ISSUE:   cnt_r <= issue_last ? '0 : cnt_r + CNT_W'(1);
            DRAIN:   cnt_r <= cnt_r + CNT_W'(1);
            default: cnt_r <= '0;
         endcase
      end
   end

   // Response tag pipeline aligned with ROM latency; tags are zero when idle.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         for (int k = 0; k < ROM_LAT; k++) begin
            valid_p[k] <= 1'b0;
            last_p[k]  <= 1'b0;
            id_p[k]    <= '0;
         end
      end else begin
         valid_p[0] <= rom_en;
         last_p[0]  <= rom_en && issue_last;
         id_p[0]    <= rom_en ? id_r : '0;
         for (int k = 1; k < ROM_LAT; k++) begin
            valid_p[k] <= valid_p[k-1];
            last_p[k]  <= last_p[k-1];
            id_p[k]    <= id_p[k-1];
         end
      end
   end

   assign rsp_valid = valid_p[ROM_LAT-1];
   assign rsp_last  = last_p[ROM_LAT-1];
   assign rsp_id    = id_p[ROM_LAT-1];
   assign rsp_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench: cycle-level reference model predicts grants, ROM issue and
// tagged responses; a scoreboard queue is drained by an independent monitor.
module tb_sprite_rom_arbiter;

   localparam int NR = 4, AW = 12, DW = 12, LAT = 2, BMAX = 16, LW = 5;

   logic              clk = 1'b0;
   logic              reset, fetch_en;
   logic [NR-1:0]     req, grant;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*LW-1:0]  req_len;
   logic              busy, rom_en, rsp_valid, rsp_last;
   logic [AW-1:0]     rom_addr;
   logic [DW-1:0]     rom_data, rsp_data;
   logic [1:0]        rsp_id;

   sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT),
                        .BURST_MAX(BMAX)) dut (
      .pixel_clk(clk), .reset(reset), .fetch_en(fetch_en), .req(req),
      .req_addr(req_addr), .req_len(req_len), .grant(grant), .busy(busy),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_last(rsp_last));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM model: data = addr ^ 0xABC, LAT cycles after the address
   logic [AW-1:0] rom_pipe [LAT];
   always @(posedge clk) begin
      rom_pipe[0] <= rom_addr;
      for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
   end
   assign rom_data = rom_pipe[LAT-1] ^ 12'hABC;

   typedef struct {
      int          cyc;
      int          id;
      logic [DW-1:0] data;
      logic        last;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0, n_fail = 0;
   int n_bursts = 0;

   // stimulus state
   logic          rst_v = 1'b1, fen_v = 1'b0, drop_on_grant = 1'b0;
   logic [NR-1:0] req_v = '0;
   logic [AW-1:0] a_v [NR];
   logic [LW-1:0] l_v [NR];

   // reference model state
   int            ptr = 0, free_at = 0, iss_start = 1, iss_end = 0, last_gid = -1;
   logic [AW-1:0] iss_base = '0;
   logic          rst_prev = 1'b0, armed = 1'b0;

   task automatic tick();
      logic [NR-1:0] exp_grant;
      logic          exp_busy, exp_en, post_rst;
      logic [AW-1:0] exp_addr;
      int            n, gi;
      exp_t          e;
      if (drop_on_grant && last_gid >= 0) req_v[last_gid] = 1'b0;
      @(posedge clk); #1;
      post_rst = rst_prev;
      if (rst_prev) begin
         sb.delete();
         free_at = cyc; iss_start = 1; iss_end = 0; ptr = 0; armed = 1'b1;
      end
      reset = rst_v; fetch_en = fen_v; req = req_v;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW] = a_v[i];
         req_len[i*LW +: LW]  = l_v[i];
      end
      exp_busy  = (cyc < free_at);
      exp_grant = '0;
      last_gid  = -1;
      if (!rst_v && !exp_busy && fen_v && req_v != '0) begin
         gi = -1;
         for (int k = 0; k < NR; k++)
            if (gi < 0 && req_v[(ptr + k) % NR]) gi = (ptr + k) % NR;
         exp_grant[gi] = 1'b1;
         n = (l_v[gi] == 0) ? 1 : ((int'(l_v[gi]) > BMAX) ? BMAX : int'(l_v[gi]));
         for (int j = 0; j < n; j++) begin
            e.cyc  = cyc + 1 + LAT + j;
            e.id   = gi;
            e.data = (a_v[gi] + AW'(j)) ^ 12'hABC;
            e.last = (j == n - 1);
            sb.push_back(e);
         end
         iss_start = cyc + 1; iss_end = cyc + n; iss_base = a_v[gi];
         free_at   = cyc + n + LAT + 1;
         ptr       = (gi + 1) % NR;
         last_gid  = gi;
         n_bursts++;
      end
      rst_prev = rst_v;
      @(negedge clk);
      if (armed) begin
         exp_en   = (cyc >= iss_start) && (cyc <= iss_end);
         exp_addr = iss_base + AW'(cyc - iss_start);
         n_checks++;
         if (grant !== exp_grant) begin
            n_fail++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, exp_grant);
         end
         n_checks++;
         if (busy !== exp_busy) begin
            n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
         end
         n_checks++;
         if (rom_en !== exp_en) begin
            n_fail++; $display("FAIL rom_en cyc=%0d got=%b exp=%b", cyc, rom_en, exp_en);
         end
         if (exp_en) begin
            n_checks++;
            if (rom_addr !== exp_addr) begin
               n_fail++; $display("FAIL rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, exp_addr);
            end
         end
         if (post_rst && !rst_v) begin
            n_checks++;
            if (rom_addr !== '0 || rsp_valid !== 1'b0) begin
               n_fail++; $display("FAIL post_reset cyc=%0d rom_addr=%h rsp_valid=%b exp 0/0",
                                  cyc, rom_addr, rsp_valid);
            end
         end
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a response word.
   always @(negedge clk) begin
      if (armed) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_missing cyc=%0d got=none exp=word for id %0d at cyc %0d",
                     cyc, sb[0].id, sb[0].cyc);
            void'(sb.pop_front());
         end
         n_checks++;
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL rsp_unexpected cyc=%0d got=valid exp=idle", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.cyc != cyc || int'(rsp_id) != e.id || rsp_data !== e.data || rsp_last !== e.last) begin
                  n_fail++;
                  $display("FAIL rsp_word cyc=%0d got id=%0d data=%h last=%b exp cyc=%0d id=%0d data=%h last=%b",
                           cyc, rsp_id, rsp_data, rsp_last, e.cyc, e.id, e.data, e.last);
               end
            end
         end else if (rsp_id !== '0 || rsp_last !== 1'b0) begin
            n_fail++; $display("FAIL rsp_idle cyc=%0d got id=%0d last=%b exp 0/0", cyc, rsp_id, rsp_last);
         end
      end
   end

   initial begin
      for (int i = 0; i < NR; i++) begin a_v[i] = '0; l_v[i] = '0; end
      reset = 1'b1; fetch_en = 1'b0; req = '0; req_addr = '0; req_len = '0;
      repeat (3) tick();
      rst_v = 1'b0; tick();

      // single request
      drop_on_grant = 1'b1;
      req_v = 4'b0001; a_v[0] = 12'h100; l_v[0] = 5'd3; fen_v = 1'b1;
      repeat (9) tick();

      // saturating round robin, len=1 each
      drop_on_grant = 1'b0;
      for (int i = 0; i < NR; i++) begin a_v[i] = AW'(12'h010 * (i + 1)); l_v[i] = 5'd1; end
      req_v = 4'b1111;
      repeat (20) tick();
      req_v = '0; repeat (6) tick();

      // fetch_en gating and drop mid-burst
      drop_on_grant = 1'b1;
      fen_v = 1'b0; req_v = 4'b0010; a_v[1] = 12'h200; l_v[1] = 5'd8;
      repeat (4) tick();
      fen_v = 1'b1; tick();
      fen_v = 1'b0; repeat (14) tick();

      // wrap, len=0, len=31
      fen_v = 1'b1;
      req_v = 4'b0001; a_v[0] = 12'hFFE; l_v[0] = 5'd4;  repeat (9) tick();
      req_v = 4'b0100; a_v[2] = 12'h300; l_v[2] = 5'd0;  repeat (6) tick();
      req_v = 4'b1000; a_v[3] = 12'h7F8; l_v[3] = 5'd31; repeat (22) tick();

      // reset at the second ISSUE cycle, then ptr must restart at 0
      req_v = 4'b0001; a_v[0] = 12'h400; l_v[0] = 5'd8;
      tick(); tick();
      rst_v = 1'b1; tick();
      rst_v = 1'b0; req_v = '0; tick();
      req_v = 4'b1001; a_v[0] = 12'h500; l_v[0] = 5'd2; a_v[3] = 12'h600; l_v[3] = 5'd2;
      repeat (16) tick();

      // randomized traffic
      req_v = '0;
      for (int c = 0; c < 40000 && n_bursts < 1040; c++) begin
         drop_on_grant = 1'b0;
         if (last_gid >= 0) begin
            if ($urandom_range(0, 3) != 0) req_v[last_gid] = 1'b0;
            else begin
               a_v[last_gid] = AW'($urandom);
               l_v[last_gid] = LW'($urandom_range(0, 31));
            end
         end
         for (int i = 0; i < NR; i++) begin
            if (!req_v[i] && $urandom_range(0, 7) == 0) begin
               req_v[i] = 1'b1;
               a_v[i] = ($urandom_range(0, 1) == 1) ? AW'($urandom) : 12'hFF0 + AW'($urandom_range(0, 15));
               l_v[i] = LW'($urandom_range(0, 31));
            end else if (req_v[i] && $urandom_range(0, 63) == 0) begin
               req_v[i] = 1'b0;
            end
         end
         fen_v = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_v = '0; fen_v = 1'b0;
      repeat (40) tick();

      n_checks++;
      if (n_bursts < 1000) begin
         n_fail++; $display("FAIL burst_count got=%0d exp>=1000", n_bursts);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
